// File: rtl/td4_sequencer_pkg.sv
// Shared definitions for the TD4 sequencer: widths, opcodes, FSM encoding
// and the result-source select codes.
package td4_sequencer_pkg;

  localparam int PC_W_DEF   = 4;
  localparam int DATA_W_DEF = 4;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_EXEC  = 1'b1;

  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_IN   = 2'd2,
    SEL_ZERO = 2'd3
  } sel_e;

endpackage

// File: rtl/td4_sequencer_decode.sv
// Opcode decoder: picks the adder source, the single load strobe (active-high
// here) and whether the PC takes the result.
module td4_decode
  import td4_sequencer_pkg::*;
(
  input  logic [3:0] op,
  input  logic       carry,
  output sel_e       sel,
  output logic       load_a,
  output logic       load_b,
  output logic       load_out,
  output logic       jump,
  output logic       is_nop
);

  always_comb begin
    sel      = SEL_ZERO;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_out = 1'b0;
    jump     = 1'b0;
    is_nop   = 1'b0;
    case (op)
      OP_ADD_A:  begin sel = SEL_A;    load_a   = 1'b1; end
      OP_MOV_AB: begin sel = SEL_B;    load_a   = 1'b1; end
      OP_IN_A:   begin sel = SEL_IN;   load_a   = 1'b1; end
      OP_MOV_AI: begin sel = SEL_ZERO; load_a   = 1'b1; end
      OP_MOV_BA: begin sel = SEL_A;    load_b   = 1'b1; end
      OP_ADD_B:  begin sel = SEL_B;    load_b   = 1'b1; end
      OP_IN_B:   begin sel = SEL_IN;   load_b   = 1'b1; end
      OP_MOV_BI: begin sel = SEL_ZERO; load_b   = 1'b1; end
      OP_OUT_B:  begin sel = SEL_B;    load_out = 1'b1; end
      OP_OUT_I:  begin sel = SEL_ZERO; load_out = 1'b1; end
      // JNC looks at the flag left by the previous instruction
      OP_JNC:    begin sel = SEL_ZERO; jump     = ~carry; end
      OP_JMP:    begin sel = SEL_ZERO; jump     = 1'b1; end
      default:   is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control unit: two-phase FETCH/EXEC sequencer owning PC, IR and carry,
// driving the shared result bus and the active-low register load strobes.
module td4_sequencer
  import td4_sequencer_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  output logic [PC_W-1:0]   ROM_ADDR,
  input  logic [7:0]        INSTR,
  input  logic [DATA_W-1:0] A_Q,
  input  logic [DATA_W-1:0] B_Q,
  input  logic [DATA_W-1:0] IN_PORT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              LOAD_A_N,
  output logic              LOAD_B_N,
  output logic              LOAD_OUT_N,
  output logic              CARRY,
  output logic              EXEC
);

  logic [0:0]        state;
  logic [PC_W-1:0]   pc;
  logic [7:0]        ir;
  logic              carry;

  sel_e              sel;
  logic              ld_a, ld_b, ld_out, jump, is_nop;
  logic [DATA_W-1:0] src, im;
  logic [DATA_W:0]   sum;
  logic [PC_W-1:0]   pc_next;
  logic              exec;

  td4_decode u_dec (
    .op       (ir[7:4]),
    .carry    (carry),
    .sel      (sel),
    .load_a   (ld_a),
    .load_b   (ld_b),
    .load_out (ld_out),
    .jump     (jump),
    .is_nop   (is_nop)
  );

  assign exec = (state == ST_EXEC);
  assign im   = DATA_W'(ir[3:0]);

  always_comb begin
    src = '0;
    case (sel)
      SEL_A:   src = A_Q;
      SEL_B:   src = B_Q;
      SEL_IN:  src = IN_PORT;
      default: src = '0;
    endcase
  end

  assign sum     = {1'b0, src} + {1'b0, im};
  assign pc_next = jump ? PC_W'(sum[DATA_W-1:0]) : pc + PC_W'(1);

  // State reset is async, so strobes fall back to 1 the moment CLR drops
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      carry <= 1'b0;
    end else if (state == ST_FETCH) begin
      ir    <= INSTR;
      state <= ST_EXEC;
    end else begin
      state <= ST_FETCH;
      pc    <= pc_next;
      carry <= is_nop ? 1'b0 : sum[DATA_W];
    end
  end

  assign ROM_ADDR   = pc;
  assign DATA_OUT   = exec ? sum[DATA_W-1:0] : '0;
  assign LOAD_A_N   = ~(exec & ld_a);
  assign LOAD_B_N   = ~(exec & ld_b);
  assign LOAD_OUT_N = ~(exec & ld_out);
  assign CARRY      = carry;
  assign EXEC       = exec;

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed bench for td4_sequencer; ROM data is driven directly on INSTR.
module tb_td4_sequencer;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] ROM_ADDR;
  logic [7:0] INSTR;
  logic [3:0] A_Q, B_Q, IN_PORT;
  logic [3:0] DATA_OUT;
  logic       LOAD_A_N, LOAD_B_N, LOAD_OUT_N, CARRY, EXEC;

  int n_chk  = 0;
  int n_fail = 0;

  td4_sequencer #(.PC_W(4), .DATA_W(4)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .ROM_ADDR   (ROM_ADDR),
    .INSTR      (INSTR),
    .A_Q        (A_Q),
    .B_Q        (B_Q),
    .IN_PORT    (IN_PORT),
    .DATA_OUT   (DATA_OUT),
    .LOAD_A_N   (LOAD_A_N),
    .LOAD_B_N   (LOAD_B_N),
    .LOAD_OUT_N (LOAD_OUT_N),
    .CARRY      (CARRY),
    .EXEC       (EXEC)
  );

  always #5 CLK = ~CLK;

  wire [2:0] strb = {LOAD_A_N, LOAD_B_N, LOAD_OUT_N};

  // From FETCH: present instr, cross the fetch edge, land 1ns into EXEC
  task automatic fetch(input logic [7:0] i);
    INSTR = i;
    @(posedge CLK); #1;
  endtask

  task automatic finish_exec();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0; INSTR = 8'h00; A_Q = 4'h0; B_Q = 4'h0; IN_PORT = 4'h0;
    repeat (3) @(posedge CLK);
    #1;
    n_chk++;
    if ({ROM_ADDR, EXEC, strb, CARRY, DATA_OUT} !== {4'h0, 1'b0, 3'b111, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_held: addr=%h exec=%b strb=%b c=%b d=%h, want 0 0 111 0 0",
               ROM_ADDR, EXEC, strb, CARRY, DATA_OUT);
    end
    CLR = 1'b1;
    #1;
    n_chk++;
    if ({ROM_ADDR, EXEC, strb, CARRY} !== {4'h0, 1'b0, 3'b111, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: addr=%h exec=%b strb=%b c=%b, want 0 0 111 0",
               ROM_ADDR, EXEC, strb, CARRY);
    end
  endtask

  task automatic test_add_carry();
    A_Q = 4'hF;
    fetch(8'h01);
    n_chk++;
    if ({EXEC, DATA_OUT, strb} !== {1'b1, 4'h0, 3'b011}) begin
      n_fail++;
      $display("FAIL add_a_exec: exec=%b d=%h strb=%b, want 1 0 011", EXEC, DATA_OUT, strb);
    end
    finish_exec();
    n_chk++;
    if ({CARRY, ROM_ADDR, EXEC, strb, DATA_OUT} !== {1'b1, 4'h1, 1'b0, 3'b111, 4'h0}) begin
      n_fail++;
      $display("FAIL add_a_after: c=%b pc=%h exec=%b strb=%b d=%h, want 1 1 0 111 0",
               CARRY, ROM_ADDR, EXEC, strb, DATA_OUT);
    end
  endtask

  task automatic test_jnc_jmp();
    fetch(8'hE5);
    n_chk++;
    if ({strb, DATA_OUT} !== {3'b111, 4'h5}) begin
      n_fail++;
      $display("FAIL jnc_exec: strb=%b d=%h, want 111 5", strb, DATA_OUT);
    end
    finish_exec();
    n_chk++;
    if ({ROM_ADDR, CARRY} !== {4'h2, 1'b0}) begin
      n_fail++;
      $display("FAIL jnc_not_taken: pc=%h c=%b, want 2 0", ROM_ADDR, CARRY);
    end
    fetch(8'hE5);
    finish_exec();
    n_chk++;
    if (ROM_ADDR !== 4'h5) begin
      n_fail++;
      $display("FAIL jnc_taken: pc=%h, want 5", ROM_ADDR);
    end
    fetch(8'hF3);
    n_chk++;
    if (strb !== 3'b111) begin
      n_fail++;
      $display("FAIL jmp_strobes: strb=%b, want 111", strb);
    end
    finish_exec();
    n_chk++;
    if (ROM_ADDR !== 4'h3) begin
      n_fail++;
      $display("FAIL jmp_target: pc=%h, want 3", ROM_ADDR);
    end
  endtask

  task automatic test_out_mov();
    A_Q = 4'hF;
    fetch(8'h01);
    finish_exec();
    fetch(8'hB7);
    n_chk++;
    if ({DATA_OUT, strb} !== {4'h7, 3'b110}) begin
      n_fail++;
      $display("FAIL out_im_exec: d=%h strb=%b, want 7 110", DATA_OUT, strb);
    end
    finish_exec();
    n_chk++;
    if ({CARRY, ROM_ADDR} !== {1'b0, 4'h5}) begin
      n_fail++;
      $display("FAIL out_im_after: c=%b pc=%h, want 0 5", CARRY, ROM_ADDR);
    end
    A_Q = 4'h9;
    fetch(8'h40);
    n_chk++;
    if ({DATA_OUT, strb} !== {4'h9, 3'b101}) begin
      n_fail++;
      $display("FAIL mov_ba_exec: d=%h strb=%b, want 9 101", DATA_OUT, strb);
    end
    finish_exec();
  endtask

  task automatic test_opcodes();
    logic [7:0] v_ins [6] = '{8'h10, 8'h20, 8'h3C, 8'h53, 8'h61, 8'h92};
    logic [3:0] v_b   [6] = '{4'hA, 4'h0, 4'h0, 4'hE, 4'h0, 4'h5};
    logic [3:0] v_in  [6] = '{4'h0, 4'h6, 4'h0, 4'h0, 4'hF, 4'h0};
    logic [3:0] v_d   [6] = '{4'hA, 4'h6, 4'hC, 4'h1, 4'h0, 4'h7};
    logic [2:0] v_s   [6] = '{3'b011, 3'b011, 3'b011, 3'b101, 3'b101, 3'b110};
    logic       v_c   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] pc0;
    A_Q = 4'h3;
    for (int k = 0; k < 6; k++) begin
      pc0 = ROM_ADDR;
      B_Q = v_b[k]; IN_PORT = v_in[k];
      fetch(v_ins[k]);
      n_chk++;
      if ({DATA_OUT, strb} !== {v_d[k], v_s[k]}) begin
        n_fail++;
        $display("FAIL op_%h_exec: d=%h strb=%b, want %h %b",
                 v_ins[k], DATA_OUT, strb, v_d[k], v_s[k]);
      end
      finish_exec();
      n_chk++;
      if ({CARRY, ROM_ADDR} !== {v_c[k], pc0 + 4'h1}) begin
        n_fail++;
        $display("FAIL op_%h_after: c=%b pc=%h, want %b %h",
                 v_ins[k], CARRY, ROM_ADDR, v_c[k], pc0 + 4'h1);
      end
    end
  endtask

  task automatic test_nop_wrap();
    logic [7:0] v_nop [4] = '{8'h8F, 8'hA5, 8'hCF, 8'hDF};
    A_Q = 4'hF;
    fetch(8'h01);
    finish_exec();
    for (int k = 0; k < 4; k++) begin
      fetch(v_nop[k]);
      n_chk++;
      if (strb !== 3'b111) begin
        n_fail++;
        $display("FAIL nop_%h_strobes: strb=%b, want 111", v_nop[k], strb);
      end
      finish_exec();
      if (k == 0) begin
        n_chk++;
        if (CARRY !== 1'b0) begin
          n_fail++;
          $display("FAIL nop_clears_carry: c=%b, want 0", CARRY);
        end
      end
    end
    fetch(8'hF0);
    finish_exec();
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if ({ROM_ADDR, strb} !== {4'(k), 3'b111}) begin
        n_fail++;
        $display("FAIL nop_run_fetch%0d: pc=%h strb=%b, want %h 111", k, ROM_ADDR, strb, 4'(k));
      end
      fetch(8'h80);
      n_chk++;
      if (strb !== 3'b111) begin
        n_fail++;
        $display("FAIL nop_run_exec%0d: strb=%b, want 111", k, strb);
      end
      finish_exec();
    end
    n_chk++;
    if (ROM_ADDR !== 4'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h, want 0", ROM_ADDR);
    end
  endtask

  task automatic test_clr_mid_exec();
    fetch(8'hF4);
    finish_exec();
    B_Q = 4'hE;
    fetch(8'h53);
    n_chk++;
    if ({strb, DATA_OUT} !== {3'b101, 4'h1}) begin
      n_fail++;
      $display("FAIL clr_pre: strb=%b d=%h, want 101 1", strb, DATA_OUT);
    end
    #2 CLR = 1'b0;
    #1;
    n_chk++;
    if ({strb, EXEC, ROM_ADDR, CARRY} !== {3'b111, 1'b0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_async: strb=%b exec=%b pc=%h c=%b, want 111 0 0 0",
               strb, EXEC, ROM_ADDR, CARRY);
    end
    @(posedge CLK); #1;
    CLR = 1'b1;
    A_Q = 4'hF;
    n_chk++;
    if ({ROM_ADDR, EXEC, CARRY} !== {4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_restart_fetch: pc=%h exec=%b c=%b, want 0 0 0", ROM_ADDR, EXEC, CARRY);
    end
    fetch(8'h01);
    n_chk++;
    if ({EXEC, ROM_ADDR, strb, DATA_OUT} !== {1'b1, 4'h0, 3'b011, 4'h0}) begin
      n_fail++;
      $display("FAIL clr_restart_exec: exec=%b pc=%h strb=%b d=%h, want 1 0 011 0",
               EXEC, ROM_ADDR, strb, DATA_OUT);
    end
    finish_exec();
    n_chk++;
    if ({ROM_ADDR, CARRY} !== {4'h1, 1'b1}) begin
      n_fail++;
      $display("FAIL clr_restart_after: pc=%h c=%b, want 1 1", ROM_ADDR, CARRY);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_jnc_jmp();
    test_out_mov();
    test_opcodes();
    test_nop_wrap();
    test_clr_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
